// File: rtl/lcd_nibble_tx_if.sv
// -----------------------------------------------------------------------------
// lcd_nibble_tx_if
//   Byte handshake bundle between the LCD text/init sequencer (master) and the
//   HD44780 4-bit transmitter (slave).
//
//   in_valid     master -> slave  byte offered
//   in_ready     slave  -> master transmitter idle; byte taken when valid & ready
//   in_data      master -> slave  command or data byte
//   in_rs        master -> slave  register select: 0 command, 1 data
//   in_nib_only  master -> slave  send only in_data[7:4] as a single nibble
// -----------------------------------------------------------------------------
interface lcd_nibble_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_rs;
    logic       in_nib_only;

    modport master (
        output in_valid,
        output in_data,
        output in_rs,
        output in_nib_only,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_rs,
        input  in_nib_only,
        output in_ready
    );
endinterface

// File: rtl/lcd_nibble_tx.sv
// -----------------------------------------------------------------------------
// lcd_nibble_tx
//   Byte-to-HD44780 4-bit bus transmitter. Each accepted byte is driven onto
//   LCD_D as {RS, high nibble} then {RS, low nibble}, each framed by a setup,
//   enable-pulse and hold phase, followed by the controller execution delay.
//   Clear/home commands (RS=0, data[7:2]=0) get the long execution delay.
//   Nibble-only bytes send just the high nibble (init wake-up writes).
//
//   CLK    in   system clock, rising edge
//   RST    in   synchronous reset, active high
//   bus    slave modport of lcd_nibble_tx_if (valid/ready byte handshake)
//   LCD_D  out  {RS, D7..D4} to the panel
//   LCD_E  out  panel enable strobe
//   done   out  one-cycle pulse when the post-transfer wait completes
// -----------------------------------------------------------------------------
module lcd_nibble_tx #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 5,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int CNT_W     = 20
) (
    input  logic              CLK,
    input  logic              RST,
    lcd_nibble_tx_if.slave    bus,
    output logic [4:0]        LCD_D,
    output logic              LCD_E,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    // Each phase loads (length - 1) and leaves when the counter hits zero.
    // The wait phase loads (length - 2) because the IDLE cycle in which
    // in_ready/done are first seen counts as the last cycle of the delay.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 2);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 2);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       lcd_d_q, lcd_d_d;
    logic             lcd_e_q, lcd_e_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             second_q, second_d;   // low nibble still to send
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;

    logic             accept;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;
    logic             long_dly;
    logic             dly_one;
    logic [CNT_W-1:0] wait_ld;

    assign accept   = bus.in_valid & ready_q;
    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);

    // Clear display (0x01) and return home (0x02/0x03) need the long delay.
    assign long_dly = ~rs_q & (data_q[7:2] == 6'd0);
    assign dly_one  = long_dly ? (LONG_CYC == 1) : (EXEC_CYC == 1);
    assign wait_ld  = long_dly ? LONG_LD : EXEC_LD;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no branch
        // of the case below can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        lcd_d_d  = lcd_d_q;
        lcd_e_d  = lcd_e_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        second_d = second_q;
        data_d   = data_q;
        rs_d     = rs_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d  = 1'b0;
                    data_d   = bus.in_data;
                    rs_d     = bus.in_rs;
                    second_d = ~bus.in_nib_only;
                    lcd_d_d  = {bus.in_rs, bus.in_data[7:4]};
                    cnt_d    = SETUP_LD;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    lcd_e_d = 1'b1;
                    cnt_d   = PULSE_LD;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    lcd_e_d = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_HOLD: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else if (second_q) begin
                    second_d = 1'b0;
                    lcd_d_d  = {rs_q, data_q[3:0]};
                    cnt_d    = SETUP_LD;
                    state_d  = S_SETUP;
                end else if (dly_one) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = wait_ld;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                lcd_e_d = 1'b0;
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lcd_d_q  <= '0;
            lcd_e_q  <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lcd_d_q  <= lcd_d_d;
            lcd_e_q  <= lcd_e_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            second_q <= second_d;
        end
    end

    // NOTE: the byte payload is left out of reset; it is only read after an
    // accept has overwritten it, so clearing it would add reset fan-out only.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        rs_q   <= rs_d;
    end

    assign bus.in_ready = ready_q;
    assign LCD_D        = lcd_d_q;
    assign LCD_E        = lcd_e_q;
    assign done         = done_q;

endmodule
